// File: rtl/stream_demux_1x2_pkg.sv
// ============================================================================
// stream_demux_1x2_pkg
// Shared state encoding and buffer depth for the 1:2 packet-locking demux.
// Revision: 1.0
// ============================================================================
`default_nettype none

package stream_demux_1x2_pkg;

  localparam int DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/demux_chan_buf.sv
// ============================================================================
// demux_chan_buf
// Two-entry output FIFO for one demux channel; slot 0 is always the head.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_chan_buf
  import stream_demux_1x2_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  output logic         full,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  logic [W-1:0] data_q [DEPTH];
  logic [W-1:0] data_d [DEPTH];
  logic         last_q [DEPTH];
  logic         last_d [DEPTH];
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         w_pop;
  logic         w_push;

  assign full      = (count_q == 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[0];
  assign out_last  = last_q[0];

  assign w_pop  = out_valid && out_ready;
  assign w_push = push && (!full || w_pop);

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10: begin
        data_d[count_q[0]] = push_data;
        last_d[count_q[0]] = push_last;
        count_d            = count_q + 2'd1;
      end
      2'b01: begin
        data_d[0] = data_q[1];
        last_d[0] = last_q[1];
        count_d   = count_q - 2'd1;
      end
      2'b11: begin
        // Shift the survivor to the head, then write the new beat behind it.
        if (count_q == 2'd2) begin
          data_d[0] = data_q[1];
          last_d[0] = last_q[1];
          data_d[1] = push_data;
          last_d[1] = push_last;
        end else begin
          data_d[0] = push_data;
          last_d[0] = push_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 2'd0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_demux_1x2.sv
// ============================================================================
// stream_demux_1x2
// Registered 1:2 stream demux; a packet stays locked to the channel chosen on
// its first beat.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stream_demux_1x2
  import stream_demux_1x2_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_sel,
  input  logic         in_last,
  output logic         out0_valid,
  input  logic         out0_ready,
  output logic [W-1:0] out0_data,
  output logic         out0_last,
  output logic         out1_valid,
  input  logic         out1_ready,
  output logic [W-1:0] out1_data,
  output logic         out1_last,
  output logic         busy
);

  state_e state_q;
  state_e state_d;
  logic   w_target;
  logic   w_accept;
  logic   w_push0;
  logic   w_push1;
  logic   w_full0;
  logic   w_full1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_accept) begin
      case (state_q)
        IDLE:    state_d = in_last ? IDLE : (in_sel ? LOCK1 : LOCK0);
        LOCK0,
        LOCK1:   state_d = in_last ? IDLE : state_q;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    w_target = 1'b0;
    case (state_q)
      IDLE:    w_target = in_sel;
      LOCK1:   w_target = 1'b1;
      default: w_target = 1'b0;
    endcase
    busy     = (state_q != IDLE);
    in_ready = w_target ? !w_full1 : !w_full0;
    w_accept = in_valid && in_ready;
    w_push0  = w_accept && !w_target;
    w_push1  = w_accept && w_target;
  end

  demux_chan_buf #(.W(W)) u_buf0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push0),
    .push_data (in_data),
    .push_last (in_last),
    .full      (w_full0),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .out_data  (out0_data),
    .out_last  (out0_last)
  );

  demux_chan_buf #(.W(W)) u_buf1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push1),
    .push_data (in_data),
    .push_last (in_last),
    .full      (w_full1),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  (out1_data),
    .out_last  (out1_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1x2.sv
// ============================================================================
// tb_stream_demux_1x2
// Directed and random stimulus against a queue-based packet model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stream_demux_1x2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_sel = 1'b0;
  logic       in_last = 1'b0;
  logic       out0_valid, out1_valid;
  logic       out0_ready = 1'b1, out1_ready = 1'b1;
  logic [7:0] out0_data, out1_data;
  logic       out0_last, out1_last;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;

  // Model: one FIFO of {last,data} per channel and the locked channel (-1 = none).
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         lock_ch = -1;

  always #5 clk = ~clk;

  stream_demux_1x2 #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int m_target();
    return (lock_ch < 0) ? int'(in_sel) : lock_ch;
  endfunction

  function automatic logic m_in_ready();
    return (m_target() == 0) ? (q0.size() < 2) : (q1.size() < 2);
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle(output logic acc);
    int  tgt;
    logic p0, p1;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
    chk("busy", 32'(busy), 32'(lock_ch >= 0));
    chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) chk("out0_beat", {23'd0, out0_last, out0_data}, 32'(q0[0]));
    if (q1.size() != 0) chk("out1_beat", {23'd0, out1_last, out1_data}, 32'(q1[0]));
    tgt = m_target();
    acc = in_valid && m_in_ready();
    p0  = (q0.size() != 0) && out0_ready;
    p1  = (q1.size() != 0) && out1_ready;
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (tgt == 0) q0.push_back({in_last, in_data});
      else          q1.push_back({in_last, in_data});
      lock_ch = in_last ? -1 : tgt;
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  // Hold a beat until accepted, with a bounded wait.
  task automatic send(input logic sel, input logic [7:0] data, input logic last);
    logic acc;
    int   k;
    in_valid = 1'b1; in_sel = sel; in_data = data; in_last = last;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 40) begin
      cycle(acc);
      k++;
    end
    if (!acc) chk("send_timeout", 32'(k), 32'(0));
    in_valid = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data", {23'd0, out0_last, out0_data}, 32'd0);
    chk("rst_out1_data", {23'd0, out1_last, out1_data}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    q0.delete();
    q1.delete();
    lock_ch = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic acc;
    // Power-on reset
    @(posedge clk);
    #1;
    async_reset();
    idle_cycles(2);

    // Single-beat packets to each channel
    send(1'b0, 8'h11, 1'b1);
    send(1'b1, 8'h22, 1'b1);
    idle_cycles(2);

    // Packet lock: in_sel flips after the first beat but the packet stays on ch1
    send(1'b1, 8'hA0, 1'b0);
    send(1'b0, 8'hA1, 1'b0);
    send(1'b0, 8'hA2, 1'b1);
    idle_cycles(2);

    // Backpressure on ch0: two beats fit, then the input stalls
    out0_ready = 1'b0;
    send(1'b0, 8'h30, 1'b1);
    send(1'b0, 8'h31, 1'b1);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h32; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      chk("bp_stalled", 32'(acc), 32'd0);
    end
    out0_ready = 1'b1;
    send(1'b0, 8'h32, 1'b1);
    send(1'b0, 8'h33, 1'b1);
    idle_cycles(3);

    // Sustained one beat per cycle through ch0
    out0_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_data = 8'(8'h40 + i); in_last = 1'(i % 4 == 3);
      cycle(acc);
      chk("stream_accept", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    idle_cycles(2);

    // Reset mid-packet with two beats held in ch1
    out1_ready = 1'b0;
    send(1'b1, 8'h50, 1'b0);
    send(1'b1, 8'h51, 1'b0);
    async_reset();
    out1_ready = 1'b1;
    send(1'b0, 8'h60, 1'b1);
    idle_cycles(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid   = 1'($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom);
      in_data    = 8'($urandom);
      in_last    = 1'($urandom_range(0, 2) == 0);
      out0_ready = 1'($urandom_range(0, 2) != 0);
      out1_ready = 1'($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    in_valid = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    idle_cycles(4);
    chk("drained0", 32'(out0_valid), 32'd0);
    chk("drained1", 32'(out1_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux_1x2.md
# stream_demux_1x2

Registered 1-to-2 stream demultiplexer with packet locking: one valid/ready input stream is steered, packet by packet, to one of two output streams selected by a sideband select bit. It is the receive-side counterpart of the 2:1 selection path and sits where a shared datapath fans back out to two consumers. Each output has a 2-entry buffer, so each channel's output handshake is registered and a stalled consumer never corrupts the other channel's data.

## Interface
Parameters:
- W, default 8: data width in bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  W  input payload.
- in_sel  input  1  destination channel; sampled only on the first beat of a packet.
- in_last  input  1  final beat of the packet.
- out0_valid, out1_valid  output  1  channel beat present.
- out0_ready, out1_ready  input  1  channel consumer ready.
- out0_data, out1_data  output  W  channel payload.
- out0_last, out1_last  output  1  channel end of packet.
- busy  output  1  high while a multi-beat packet is locked (FSM not IDLE).

## Operation
- FSM states: IDLE, LOCK0, LOCK1. Reset state is IDLE.
- Target channel: in IDLE it is in_sel. In LOCKc it is c, and in_sel is ignored.
- in_ready = NOT full(target buffer). This is combinational from in_sel in IDLE and from state otherwise.
- Accepted beat: data and last are pushed into the target channel's buffer.
- Transitions, evaluated on accepted beats only:
  - IDLE with in_last=0 goes to LOCK(in_sel).
  - IDLE with in_last=1 stays in IDLE (single-beat packet).
  - LOCKc with in_last=1 goes to IDLE.
  - LOCKc with in_last=0 stays in LOCKc.
- No accepted beat means no state change, even if in_valid toggles or in_sel changes mid-packet.
- Per-channel buffer:
  - 2-entry FIFO with count 0..2.
  - outc_valid = (count != 0). outc_data and outc_last come from the head entry.
  - Pop on outc_valid && outc_ready.
  - Push and pop in the same cycle are allowed when count is 1 or 2. The count is unchanged and order is preserved.
  - There is no push when full, because in_ready=0.
  - There is no pass-through when empty: an accepted beat is visible only on the following cycle.
- Head-of-line blocking is intended. A full target stalls the input even if the other channel has space.
- busy = (state != IDLE).
- Reset values:
  - State IDLE; both counts 0.
  - out0_valid=out1_valid=0; out*_data=0; out*_last=0; busy=0.
  - in_ready=1, because both buffers are empty.
- Reset asserted mid-packet discards all buffered beats and the lock. The upstream restarts on a packet boundary.

## Timing
- Latency: a beat accepted at rising edge N is presented on outc_valid/outc_data after edge N and stays there until popped.
- Throughput: 1 beat/cycle per channel while the consumer holds outc_ready=1.
- in_ready falls in the cycle after the target count reaches 2 without a pop. It rises in the cycle after a pop.
- Output data and last are stable while outc_valid=1 && outc_ready=0. This is standard valid/ready: valid is not withdrawn until accepted.
- A packet's beats stay contiguous on their channel. The other channel may carry nothing from this packet.

## Structure
- Shared package: state encoding enum (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2) and the buffer depth constant DEPTH=2.
- Sub-module demux_chan_buf, instantiated twice:
  - Parameter: W.
  - Ports: clk, rst_n, push, push_data, push_last, full, out_valid, out_ready, out_data, out_last.
- The top holds the FSM, target decode, in_ready and push steering.

## Test plan
- Reset then idle: rst_n low mid-run, with no clk edge -> all out*_valid=0, busy=0, in_ready=1 immediately.
- Single-beat packets: in_sel=0 data 0x11 last=1, then in_sel=1 data 0x22 last=1, both outputs ready -> 0x11 on out0 one cycle after accept, 0x22 on out1 one cycle after its accept, busy stays 0.
- Packet lock: 3-beat packet 0xA0,0xA1,0xA2 with in_sel=1 on beat 1 and in_sel=0 on beats 2-3 -> all three beats appear on out1 in order with out1_last only on 0xA2, busy high from after beat 1 until after beat 3.
- Backpressure: out0_ready=0, stream 4 beats to ch0 -> exactly 2 accepted, then in_ready=0. Release out0_ready -> remaining beats drain in order with no duplicate or loss. out1 is idle throughout.
- Simultaneous push/pop at count=1 with out0_ready=1 continuously -> count stays 1, one beat/cycle sustained over 16 beats, data order intact.
- Reset mid-packet: assert rst_n low after beat 2 of a 4-beat ch1 packet with 2 beats buffered -> out1_valid=0, busy=0. Next packet with in_sel=0 routes to out0.
